// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_BITS = 8;

endpackage : serial_adder_pkg

// File: rtl/adder_1bit.sv
// Single-bit full adder cell, time-shared by the serial adder controller.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule : adder_1bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: captures operands on start, then feeds one bit per clock
// through a shared adder_1bit cell, LSB first, recirculating the carry.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    state_t              r_state;
    logic [NUM_BITS-1:0] r_aSr;
    logic [NUM_BITS-1:0] r_bSr;
    logic [NUM_BITS-1:0] r_partial;
    logic [NUM_BITS-1:0] r_sum;
    logic                r_carry;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_bitCnt;

    state_t              w_stateNext;
    logic                w_load;
    logic                w_step;
    logic                w_finish;
    logic                w_cellSum;
    logic                w_cellCarry;
    logic [CNT_W-1:0]    w_cntInc;
    logic                w_incCarry;

    adder_1bit u_adder (
        .a         (r_aSr[0]),
        .b         (r_bSr[0]),
        .carry_in  (r_carry),
        .sum       (w_cellSum),
        .carry_out (w_cellCarry)
    );

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = ADD;
                    w_load      = 1'b1;
                end
            end
            ADD: begin
                w_step = 1'b1;
                if (r_bitCnt == LAST_BIT) begin
                    w_stateNext = DONE;
                    w_finish    = 1'b1;
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Ripple incrementer for the bit counter so the block holds no behavioural adder.
    always_comb begin
        w_cntInc   = '0;
        w_incCarry = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            w_cntInc[i] = r_bitCnt[i] ^ w_incCarry;
            w_incCarry  = r_bitCnt[i] & w_incCarry;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_aSr      <= '0;
            r_bSr      <= '0;
            r_partial  <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_bitCnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_load) begin
                r_aSr    <= a;
                r_bSr    <= b;
                r_carry  <= carry_in;
                r_bitCnt <= '0;
            end
            if (w_step) begin
                r_carry   <= w_cellCarry;
                r_aSr     <= r_aSr >> 1;
                r_bSr     <= r_bSr >> 1;
                r_partial <= {w_cellSum, r_partial[NUM_BITS-1:1]};
                r_bitCnt  <= w_cntInc;
            end
            // The last cell output goes straight into the result, bypassing the partial register.
            if (w_finish) begin
                r_sum      <= {w_cellSum, r_partial[NUM_BITS-1:1]};
                r_overflow <= w_cellCarry;
            end
        end
    end

    assign busy     = (r_state == ADD);
    assign done     = (r_state == DONE);
    assign sum      = r_sum;
    assign overflow = r_overflow;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, random vectors
// against an arithmetic model, and hand-written multi-cycle corner sequences.
module tb_serial_adder_ctrl;

    localparam int NUM_BITS = 8;

    logic                clk;
    logic                n_rst;
    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                carry_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] sum;
    logic                overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NUM_BITS-1:0] a;
        logic [NUM_BITS-1:0] b;
        logic                cin;
        logic [NUM_BITS-1:0] expSum;
        logic                expOvf;
        string               tag;
    } vec_t;

    vec_t vecs[4];

    serial_adder_ctrl #(.NUM_BITS(NUM_BITS)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Runs one addition with a single-cycle start, scrambling the inputs right after
    // the accepting edge, and checks timing, result and hold behaviour.
    task automatic applyStimulus(input logic [NUM_BITS-1:0] va, input logic [NUM_BITS-1:0] vb,
                                 input logic vc, input logic [NUM_BITS-1:0] es,
                                 input logic eo, input string tag);
        int  lat;
        int  busyCnt;
        bit  seen;
        @(negedge clk);
        a = va; b = vb; carry_in = vc; start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = NUM_BITS'($urandom);
        b        = NUM_BITS'($urandom);
        carry_in = 1'($urandom);
        lat = -1; busyCnt = 0; seen = 1'b0;
        for (int i = 1; i <= NUM_BITS + 8 && !seen; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(NUM_BITS + 1));
        checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'(NUM_BITS));
        checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_sumHold"}, 32'({overflow, sum}), 32'({eo, es}));
    endtask

    initial begin
        int doneCount;
        int busyAfter;
        int pulses;
        int lastDone;
        bit gotDone;
        logic [NUM_BITS:0] full;
        logic [NUM_BITS-1:0] ra, rb;
        logic rc;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "vec35p4A"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "vecFFp01"};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "vecFFcin"};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "vecFFpFF"};

        n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        #12;
        checkOutput("resetOutputs", 32'({busy, done, sum, overflow}), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idleHold", 32'({busy, done, sum, overflow}), 32'd0);
        end

        for (int i = 0; i < 4; i++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].expSum, vecs[i].expOvf, vecs[i].tag);

        for (int i = 0; i < 12; i++) begin
            ra = NUM_BITS'($urandom);
            rb = NUM_BITS'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{NUM_BITS{1'b0}}, rc};
            applyStimulus(ra, rb, rc, full[NUM_BITS-1:0], full[NUM_BITS], "random");
        end

        // Start pulse and operand changes in the middle of an addition must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h20; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'h77;
        repeat (3) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h33; b = 8'hCC;
        doneCount = 0; busyAfter = 0; gotDone = 1'b0;
        for (int i = 0; i < 2 * NUM_BITS + 6; i++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (!gotDone) checkOutput("midStartSum", 32'({overflow, sum}), 32'h030);
                gotDone = 1'b1;
            end else if (gotDone && busy) begin
                busyAfter++;
            end
        end
        checkOutput("midStartDoneCount", 32'(doneCount), 32'd1);
        checkOutput("midStartNoRestart", 32'(busyAfter), 32'd0);

        // Reset during the 4th ADD cycle abandons the operation and clears the result.
        @(negedge clk);
        a = 8'h40; b = 8'h40; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("preResetBusy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("midResetOutputs", 32'({busy, done, sum, overflow}), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        doneCount = 0;
        for (int i = 0; i < NUM_BITS + 3; i++) begin
            @(negedge clk);
            if (done || busy) doneCount++;
        end
        checkOutput("postResetQuiet", 32'(doneCount), 32'd0);
        applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "afterReset");

        // Continuous start: automatic restart every NUM_BITS+2 cycles.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        pulses = 0; lastDone = -1;
        for (int cyc = 0; cyc < 4 * (NUM_BITS + 2) + 2; cyc++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lastDone >= 0) checkOutput("b2bSpacing", 32'(cyc - lastDone), 32'(NUM_BITS + 2));
                else checkOutput("b2bFirstDone", 32'(cyc), 32'(NUM_BITS));
                checkOutput("b2bSum", 32'({overflow, sum}), 32'h010);
                lastDone = cyc;
            end else if (lastDone >= 0) begin
                checkOutput("b2bHold", 32'({overflow, sum}), 32'h010);
            end
        end
        checkOutput("b2bPulses", 32'(pulses), 32'd4);
        start = 1'b0;
        for (int i = 0; i < NUM_BITS + 4 && (busy || done); i++) @(negedge clk);
        checkOutput("drainIdle", 32'({busy, done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
